clock_enable_generator: RTL and testbench

Parametrised, fully synchronous clock-enable generator: derives `NUM_CLOCKS` independent divided rates, with per-channel divisor and phase, from a single reference clock. Each channel provides a one-cycle enable pulse and an optional registered square wave. A `locked` indication is produced by a programmable settle sequencer. It sits beside the PLL wrapper and supplies the low-rate timebases (scan cycles, peripheral ticks) that need no dedicated PLL output.

---
 rtl/clock_enable_generator.sv | 125 ++++++++++++
 tb/tb_clock_enable_generator.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/clock_enable_generator.sv
// Divides refclk into NUM_CLOCKS enable pulses (plus optional square waves under CLKGEN_SQUARE_OUT_EN),
// each with its own divisor and start phase. A settle sequencer raises locked LOCK_CYCLES edges after reset or cfg_load.
module clock_enable_generator #(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int LOCK_CYCLES = 256
) (
  input  logic                            refclk,
  input  logic                            rst,
  input  logic [NUM_CLOCKS*DIV_WIDTH-1:0] div_i,
  input  logic [NUM_CLOCKS*DIV_WIDTH-1:0] phase_i,
  input  logic                            cfg_load,
  output logic [NUM_CLOCKS-1:0]           outclk_ce,
  output logic [NUM_CLOCKS-1:0]           outclk,
  output logic                            locked
);

  localparam int SW = $clog2(LOCK_CYCLES + 1);
  localparam logic [SW-1:0]        S_ONE  = SW'(1);
  localparam logic [SW-1:0]        S_LAST = SW'(LOCK_CYCLES);
  localparam logic [DIV_WIDTH-1:0] D_ONE  = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] D_ZERO = '0;

  typedef enum logic [1:0] {ST_RESET, ST_SETTLE, ST_RUN} state_t;

  state_t                                 state_q, state_d;
  logic [SW-1:0]                          settle_q, settle_d;
  logic [NUM_CLOCKS-1:0][DIV_WIDTH-1:0]   div_q, div_d;
  logic [NUM_CLOCKS-1:0][DIV_WIDTH-1:0]   phase_q, phase_d;
  logic [NUM_CLOCKS-1:0][DIV_WIDTH-1:0]   cnt_q, cnt_d;

  function automatic logic [DIV_WIDTH-1:0] eff_phase(input logic [DIV_WIDTH-1:0] d,
                                                     input logic [DIV_WIDTH-1:0] p);
    return (p < d) ? p : D_ZERO;
  endfunction

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    div_d    = div_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    if (cfg_load && (state_q != ST_RESET)) begin
      state_d  = ST_SETTLE;
      settle_d = '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_d[i]   = div_i[i*DIV_WIDTH +: DIV_WIDTH];
        phase_d[i] = phase_i[i*DIV_WIDTH +: DIV_WIDTH];
        cnt_d[i]   = eff_phase(div_i[i*DIV_WIDTH +: DIV_WIDTH], phase_i[i*DIV_WIDTH +: DIV_WIDTH]);
      end
    end else begin
      case (state_q)
        // RESET only lasts until the first edge with rst high, then counts like SETTLE
        ST_RESET, ST_SETTLE: begin
          settle_d = settle_q + S_ONE;
          state_d  = (settle_d == S_LAST) ? ST_RUN : ST_SETTLE;
          for (int i = 0; i < NUM_CLOCKS; i++) begin
            cnt_d[i] = eff_phase(div_q[i], phase_q[i]);
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NUM_CLOCKS; i++) begin
            if ((div_q[i] == D_ZERO) || (cnt_q[i] == div_q[i] - D_ONE)) begin
              cnt_d[i] = D_ZERO;
            end else begin
              cnt_d[i] = cnt_q[i] + D_ONE;
            end
          end
        end
        default: state_d = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RESET;
      settle_q <= '0;
      div_q    <= '0;
      phase_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
    end
  end

  assign locked = (state_q == ST_RUN);

  always_comb begin
    outclk_ce = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      outclk_ce[i] = locked && (div_q[i] != D_ZERO) && (cnt_q[i] == div_q[i] - D_ONE);
    end
  end

`ifdef CLKGEN_SQUARE_OUT_EN
  logic [NUM_CLOCKS-1:0] outclk_q, outclk_d;

  // High for ceil(D/2) counts, so odd divisors get the longer high phase
  always_comb begin
    outclk_d = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      outclk_d[i] = locked && (div_q[i] != D_ZERO) &&
                    (cnt_q[i] < ((div_q[i] >> 1) + DIV_WIDTH'(div_q[i][0])));
    end
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      outclk_q <= '0;
    end else begin
      outclk_q <= outclk_d;
    end
  end

  assign outclk = outclk_q;
`else
  assign outclk = '0;
`endif

endmodule

// File: tb/tb_clock_enable_generator.sv
// Directed bench for clock_enable_generator with LOCK_CYCLES=8; outclk expectations follow CLKGEN_SQUARE_OUT_EN.
module tb_clock_enable_generator;

  localparam int NC = 4;
  localparam int DW = 8;
  localparam int LC = 8;

  logic              refclk;
  logic              rst;
  logic [NC*DW-1:0]  div_i;
  logic [NC*DW-1:0]  phase_i;
  logic              cfg_load;
  logic [NC-1:0]     outclk_ce;
  logic [NC-1:0]     outclk;
  logic              locked;

  int n_assert;
  int n_fail;
  int dv [NC];
  int ph [NC];

  clock_enable_generator #(.NUM_CLOCKS(NC), .DIV_WIDTH(DW), .LOCK_CYCLES(LC)) dut (
    .refclk    (refclk),
    .rst       (rst),
    .div_i     (div_i),
    .phase_i   (phase_i),
    .cfg_load  (cfg_load),
    .outclk_ce (outclk_ce),
    .outclk    (outclk),
    .locked    (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic set_cfg();
    for (int i = 0; i < NC; i++) begin
      div_i[i*DW +: DW]   = DW'(dv[i]);
      phase_i[i*DW +: DW] = DW'(ph[i]);
    end
  endtask

  // Strobe cfg_load for one edge: locked must fall at that edge.
  task automatic do_load(input string tag);
    set_cfg();
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk({tag, "_lock_drop"}, {3'b0, locked}, 4'b0000);
    chk({tag, "_ce_drop"}, outclk_ce, 4'b0000);
  endtask

  // Eight settle edges: locked only after the last, no enables before it.
  task automatic settle(input string tag);
    for (int j = 1; j <= LC; j++) begin
      tick();
      chk({tag, "_locked"}, {3'b0, locked}, (j == LC) ? 4'b0001 : 4'b0000);
      if (j < LC) chk({tag, "_ce_quiet"}, outclk_ce, 4'b0000);
    end
  endtask

  // Starts in RUN cycle 1; expected outputs from counter arithmetic on dv/ph.
  task automatic run_check(input string tag, input int ncyc);
    logic [3:0] e_ce, e_oc;
    int pe, cn, cp;
    for (int n = 1; n <= ncyc; n++) begin
      if (n > 1) tick();
      e_ce = '0;
      e_oc = '0;
      for (int i = 0; i < NC; i++) begin
        if (dv[i] != 0) begin
          pe = (ph[i] < dv[i]) ? ph[i] : 0;
          cn = (pe + n - 1) % dv[i];
          e_ce[i] = (cn == dv[i] - 1);
`ifdef CLKGEN_SQUARE_OUT_EN
          if (n >= 2) begin
            cp = (pe + n - 2) % dv[i];
            e_oc[i] = (cp < (dv[i] + 1) / 2);
          end
`endif
        end
      end
      chk({tag, "_locked"}, {3'b0, locked}, 4'b0001);
      chk({tag, "_ce"}, outclk_ce, e_ce);
      chk({tag, "_outclk"}, outclk, e_oc);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b0;
    cfg_load = 1'b0;
    div_i    = '0;
    phase_i  = '0;
    for (int i = 0; i < NC; i++) begin
      dv[i] = 0;
      ph[i] = 0;
    end

    #1;
    chk("reset_locked", {3'b0, locked}, 4'b0000);
    chk("reset_ce", outclk_ce, 4'b0000);
    chk("reset_outclk", outclk, 4'b0000);
    tick();
    tick();
    chk("reset_hold_ce", outclk_ce, 4'b0000);

    // Release; a cfg_load on edge 1 lands in RESET and must be ignored.
    rst = 1'b1;
    div_i = {4{8'd3}};
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("edge1_locked", {3'b0, locked}, 4'b0000);
    for (int j = 2; j <= LC; j++) begin
      tick();
      chk("boot_locked", {3'b0, locked}, (j == LC) ? 4'b0001 : 4'b0000);
    end
    run_check("boot_run", 6);

    dv[0] = 4; ph[0] = 0;
    dv[1] = 5; ph[1] = 0;
    dv[2] = 1; ph[2] = 0;
    dv[3] = 4; ph[3] = 2;
    do_load("load1");
    settle("load1_settle");
    run_check("mix_run", 20);

    // Out-of-range phase behaves as phase 0
    ph[0] = 7;
    do_load("load2");
    settle("load2_settle");
    run_check("p7_run", 12);

    tick();
    dv[0] = 6; ph[0] = 0;
    do_load("load3");
    settle("load3_settle");
    run_check("d6_run", 14);

    rst = 1'b0;
    #1;
    chk("async_rst_locked", {3'b0, locked}, 4'b0000);
    chk("async_rst_ce", outclk_ce, 4'b0000);
    chk("async_rst_outclk", outclk, 4'b0000);
    tick();
    chk("rst_hold_ce", outclk_ce, 4'b0000);
    rst = 1'b1;
    for (int i = 0; i < NC; i++) begin
      dv[i] = 0;
      ph[i] = 0;
    end
    settle("rerelease");
    run_check("cfg_lost_run", 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
